ex_alu_unit: RTL

Registered 64-bit execute unit that consumes the ALU operand-B mux output and the register-file operand A, and produces ALUResult and Zero for the memory/write-back stage. Single-cycle LEGv8 logic/arithmetic ops complete in one clock; an optional iterative multiply takes 64 extra cycles. Valid/ready handshakes on both sides allow the unit to stall the datapath during long ops and absorb downstream back-pressure.

---
 rtl/ex_alu_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ex_alu_unit.sv
// ex_alu_unit: registered 64-bit LEGv8 execute unit.
//
// Single-cycle logic/arithmetic ops complete on the accept edge. An optional
// shift/add multiply occupies the EXEC state for WIDTH cycles. Valid/ready
// handshakes on both sides stall upstream during long ops and absorb
// downstream back-pressure.
//
// Optional feature macro: MUL_EN (compiles in opcode 1000 MUL, the EXEC
// state, the shift/accumulate datapath and the iteration counter).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operands and opcode valid this cycle
//   in_ready   unit can accept an op this cycle (combinational from state)
//   Data1      operand A (register read port 1)
//   mux2out    operand B (ALUSrc-selected register or immediate)
//   ALUCtrl    4-bit opcode
//   out_valid  ALUResult/Zero valid
//   out_ready  consumer accepts the result
//   ALUResult  registered result
//   Zero       registered; 1 when ALUResult == 0
//   busy       high while a multiply iterates
module ex_alu_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Data1,
  input  logic [WIDTH-1:0] mux2out,
  input  logic [3:0]       ALUCtrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1000;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             accept_c;

`ifdef MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Single-cycle op decode; unknown opcodes (and MUL) yield zero here.
  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a + ~b + WIDTH'(1);
      OP_PASS: r = b;
      OP_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Handshake status
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_c  = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign ALUResult = result_q;
  assign Zero      = zero_q;
`ifdef MUL_EN
  assign busy      = (state_q == EXEC);
`else
  assign busy      = 1'b0;
`endif

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
`ifdef MUL_EN
          if (ALUCtrl == OP_MUL) begin
            mcand_d  = Data1;
            mplier_d = mux2out;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = EXEC;
          end else begin
            result_d = alu_op(ALUCtrl, Data1, mux2out);
            zero_d   = (result_d == '0);
            state_d  = DONE;
          end
`else
          result_d = alu_op(ALUCtrl, Data1, mux2out);
          zero_d   = (result_d == '0);
          state_d  = DONE;
`endif
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef MUL_EN
      EXEC: begin
        // One shift/add step per cycle; the last step lands in ALUResult.
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = acc_d;
          zero_d   = (acc_d == '0);
          state_d  = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule
